// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and sampling constants.
package uart_rx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_CHECK  = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP,
    CHECK  = ST_CHECK
  } rx_state_e;

  // The three majority samples sit at P/2-1..P/2+1, so results are final two edges past P/2.
  localparam int SAMP_OFFSET = 2;

endpackage

// File: rtl/uart_edge_bit_counter.sv
// Oversampling edge counter and frame bit counter; the edge count wraps at presc-1
// and each wrap advances the bit count.
module uart_edge_bit_counter #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] presc,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt
);

  logic last_edge;

  assign last_edge = (edge_cnt == presc - PRESCALE_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (en) begin
      if (last_edge) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + 4'd1;
      end else begin
        edge_cnt <= edge_cnt + PRESCALE_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive sequencer: detects the start edge, walks start/data/parity/stop bits
// and strobes the datapath enables; pulses data_valid for an error-free frame.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  dat_samp_en,
  output logic                  strt_chk_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  deser_en,
  output logic                  data_valid
);

  rx_state_e             state, next_state;
  logic [PRESCALE_W-1:0] presc_q;
  logic                  par_en_q;
  logic [PRESCALE_W-1:0] samp_pt;
  logic                  last_edge;
  logic                  last_data;
  logic                  cnt_clr;
  logic                  frame_start;

  assign samp_pt   = (presc_q >> 1) + PRESCALE_W'(SAMP_OFFSET);
  assign last_edge = (edge_cnt == presc_q - PRESCALE_W'(1));
  assign last_data = last_edge && (bit_cnt == 4'(DATA_WIDTH));

  // NOTE: every signal written in always_comb gets a default first, so no path
  // through the case statement can leave a value held (which would infer a latch).
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!RX_IN) next_state = START;
      START:   if (last_edge) next_state = strt_glitch ? IDLE : DATA;
      DATA:    if (last_data) next_state = PAR_EN ? PARITY : STOP;
      PARITY:  if (last_edge) next_state = STOP;
      STOP:    if (edge_cnt == samp_pt) next_state = CHECK;
      CHECK:   next_state = RX_IN ? IDLE : START;
      default: next_state = IDLE;
    endcase
  end

  // Counters run only while a bit is in flight; IDLE and CHECK hold them at zero.
  assign cnt_clr     = (next_state == IDLE) || (next_state == CHECK);
  assign frame_start = (state == IDLE || state == CHECK) && (next_state == START);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      presc_q    <= '0;
      par_en_q   <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      state <= next_state;
      if (frame_start) presc_q <= Prescale;
      if (state == DATA && last_data) par_en_q <= PAR_EN;
      // Error flags are final at the stop sample point, so validity is judged on entry to CHECK.
      data_valid <= (state == STOP) && (next_state == CHECK) &&
                    !stp_err && !(par_en_q && par_err);
    end
  end

  uart_edge_bit_counter #(
    .PRESCALE_W (PRESCALE_W)
  ) u_counter (
    .clk      (CLK),
    .rst      (RST),
    .en       (!cnt_clr),
    .clr      (cnt_clr),
    .presc    (presc_q),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt)
  );

  assign dat_samp_en = (state == START) || (state == DATA) ||
                       (state == PARITY) || (state == STOP);
  assign strt_chk_en = (state == START);
  assign par_chk_en  = (state == PARITY);
  assign stp_chk_en  = (state == STOP);
  assign deser_en    = (state == DATA) && (edge_cnt == samp_pt);

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: frame table, reset/abort sequences and random
// frames, all compared cycle by cycle against a timeline computed from bit arithmetic.
module tb_uart_rx_fsm;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic [5:0] Prescale;
  logic       strt_glitch;
  logic       par_err;
  logic       stp_err;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       samp;
    logic       strt;
    logic       par;
    logic       stp;
    logic       deser;
    logic       valid;
  } outs_t;

  typedef struct {
    int         presc;
    bit         par_en;
    bit         glitch;
    bit         par_err;
    bit         stp_err;
    logic [7:0] data;
    bit         chain;
    int         n_deser;
    int         n_valid;
  } vec_t;

  uart_rx_fsm dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .PAR_EN      (PAR_EN),
    .Prescale    (Prescale),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .dat_samp_en (dat_samp_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .deser_en    (deser_en),
    .data_valid  (data_valid)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic outs_t sample_dut();
    outs_t o;
    o = '{edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid};
    return o;
  endfunction

  // Expected outputs 'rel' cycles after the IDLE cycle that saw the start edge.
  // Bit b of the frame spans rel = b*P .. b*P+P-1; the stop bit is cut at P/2+2.
  function automatic outs_t exp_out(input int presc, input bit par_en, input bit glitch,
                                    input bit ok, input int rel);
    outs_t o;
    int    samp, stop_bit, chk, b, e;
    o        = '0;
    samp     = presc / 2 + 2;
    stop_bit = par_en ? 10 : 9;
    chk      = stop_bit * presc + samp + 1;
    b        = rel / presc;
    e        = rel % presc;
    if (glitch) begin
      if (rel >= 1 && rel < presc) begin
        o.edge_cnt = 6'(e);
        o.samp     = 1'b1;
        o.strt     = 1'b1;
      end
    end else if (rel == chk) begin
      o.valid = ok;
    end else if (rel >= 1 && rel < chk) begin
      o.edge_cnt = 6'(e);
      o.bit_cnt  = 4'(b);
      o.samp     = 1'b1;
      o.strt     = (b == 0);
      o.par      = par_en && (b == 9);
      o.stp      = (b == stop_bit);
      o.deser    = (b >= 1) && (b <= 8) && (e == samp);
    end
    return o;
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      RX_IN = 1'b1;
      check("idle outputs", sample_dut(), '0);
    end
  endtask

  // Drives one frame cycle by cycle and compares every cycle against exp_out.
  // wiggle: disturb Prescale mid-frame and flip PAR_EN after the last data edge.
  task automatic run_frame(input int presc, input bit par_en, input bit glitch,
                           input bit perr, input bit serr, input logic [7:0] data,
                           input bit chain_in, input bit chain_out, input bit wiggle,
                           input int abort_at, output int n_deser, output int n_valid);
    int samp, chk, last, b, alt;
    bit ok;
    samp     = presc / 2 + 2;
    chk      = (par_en ? 10 : 9) * presc + samp + 1;
    last     = glitch ? presc : (chain_out ? chk : chk + 1);
    ok       = !serr && !(par_en && perr);
    alt      = (presc == 8) ? 32 : 8;
    n_deser  = 0;
    n_valid  = 0;
    for (int rel = chain_in ? 1 : 0; rel <= last; rel++) begin
      @(posedge CLK); #1;
      b = rel / presc;
      if (glitch)                 RX_IN = (rel < 2) ? 1'b0 : 1'b1;
      else if (rel >= chk)        RX_IN = (rel == chk && chain_out) ? 1'b0 : 1'b1;
      else if (b == 0)            RX_IN = 1'b0;
      else if (b <= 8)            RX_IN = data[b-1];
      else if (b == 9 && par_en)  RX_IN = ^data;
      else                        RX_IN = !serr;
      Prescale    = (wiggle && rel > 0 && rel < (glitch ? presc : chk)) ? 6'(alt) : 6'(presc);
      PAR_EN      = (wiggle && rel >= 9 * presc) ? !par_en : par_en;
      strt_glitch = glitch;
      par_err     = perr;
      stp_err     = serr;
      check($sformatf("frame P=%0d pe=%0b rel=%0d", presc, par_en, rel),
            sample_dut(), exp_out(presc, par_en, glitch, ok, rel));
      if (deser_en)   n_deser++;
      if (data_valid) n_valid++;
      if (rel == abort_at) begin
        RST = 1'b1;
        return;
      end
    end
  endtask

  vec_t vecs[$];
  int   nd, nv;

  initial begin
    RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; Prescale = 6'd8;
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset state", sample_dut(), '0);
    RST = 1'b0;
    idle_cycles(2);

    //           P  pe gl pr se data   ch deser valid
    vecs.push_back('{8,  0, 0, 0, 0, 8'hA5, 0, 8, 1});
    vecs.push_back('{16, 1, 0, 1, 0, 8'h3C, 0, 8, 0});
    vecs.push_back('{16, 0, 1, 0, 0, 8'h00, 0, 0, 0});
    vecs.push_back('{8,  0, 1, 0, 0, 8'h00, 0, 0, 0});
    vecs.push_back('{32, 0, 0, 0, 1, 8'h5A, 0, 8, 0});
    vecs.push_back('{8,  0, 0, 0, 0, 8'h11, 1, 8, 1});
    vecs.push_back('{8,  1, 0, 0, 0, 8'h22, 0, 8, 1});
    vecs.push_back('{16, 1, 0, 0, 0, 8'hF0, 0, 8, 1});
    vecs.push_back('{8,  0, 0, 1, 0, 8'h81, 0, 8, 1});
    vecs.push_back('{32, 1, 0, 1, 1, 8'h7E, 0, 8, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      run_frame(vecs[i].presc, vecs[i].par_en, vecs[i].glitch, vecs[i].par_err,
                vecs[i].stp_err, vecs[i].data, (i > 0) && vecs[i-1].chain,
                vecs[i].chain, 1'b0, -1, nd, nv);
      check($sformatf("vec%0d deser_en pulses", i), 32'(nd), 32'(vecs[i].n_deser));
      check($sformatf("vec%0d data_valid pulses", i), 32'(nv), 32'(vecs[i].n_valid));
      if (!vecs[i].chain) idle_cycles(2);
    end

    // Reset while in DATA at bit 4, then a clean frame must still be received.
    run_frame(8, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 4 * 8 + 3, nd, nv);
    @(posedge CLK); #1;
    check("outputs after mid-frame reset", sample_dut(), '0);
    RST   = 1'b0;
    RX_IN = 1'b1;
    idle_cycles(1);
    run_frame(8, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, -1, nd, nv);
    check("post-reset frame data_valid", 32'(nv), 32'd1);

    // Prescale/PAR_EN disturbed mid-frame must not alter the current frame.
    run_frame(16, 1'b1, 1'b0, 1'b1, 1'b0, 8'h96, 1'b0, 1'b0, 1'b1, -1, nd, nv);
    check("par_en flip after data: still error", 32'(nv), 32'd0);
    run_frame(8, 1'b0, 1'b0, 1'b1, 1'b0, 8'h69, 1'b0, 1'b0, 1'b1, -1, nd, nv);
    check("par_en flip after data: still valid", 32'(nv), 32'd1);

    begin
      bit prev_chain = 1'b0;
      int prev_p = 8;
      for (int i = 0; i < 24; i++) begin
        int p; bit pe, gl, pr, se, ch, wig; logic [7:0] d;
        p   = prev_chain ? prev_p : (8 << $urandom_range(0, 2));
        pe  = 1'($urandom_range(0, 1));
        gl  = !prev_chain && ($urandom_range(0, 7) == 0);
        pr  = ($urandom_range(0, 3) == 0);
        se  = ($urandom_range(0, 3) == 0);
        d   = 8'($urandom);
        ch  = !gl && (i < 23) && ($urandom_range(0, 2) == 0);
        wig = 1'($urandom_range(0, 1));
        run_frame(p, pe, gl, pr, se, d, prev_chain, ch, wig, -1, nd, nv);
        check($sformatf("rand%0d deser_en pulses", i), 32'(nd), gl ? 32'd0 : 32'd8);
        check($sformatf("rand%0d data_valid pulses", i), 32'(nv),
              32'(!gl && !se && !(pe && pr)));
        if (!ch) idle_cycles($urandom_range(0, 3));
        prev_chain = ch;
        prev_p     = p;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
